uart_result_tx: RTL
===================

// Module: uart_result_tx
// PURPOSE
//   UART 8N1 transmitter that returns inference results to the host PC.
//   On a start pulse it latches a NUM_BYTES-wide result word and sends one frame:
//   SYNC_BYTE, then the payload bytes LSB-byte-first, then an XOR checksum byte.
//   It is the host-bound counterpart of the image-receive UART and shares its
//   clock and baud settings.
// PARAMETERS
//   CLK_FREQ   50000000  system clock frequency, Hz
//   BAUD_RATE  115200    line rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer divide, 434)
//   NUM_BYTES  4         payload bytes per frame (>=1)
//   SYNC_BYTE  8'hA5     frame header byte
// PORTS
//   clk      in   1              system clock, rising edge
//   rst      in   1              reset, asynchronous, active-high
//   start    in   1              request to send a frame; sampled only while busy=0
//   payload  in   8*NUM_BYTES    result word; byte k = payload[8k+7:8k]
//   tx       out  1              UART serial line, idle high
//   busy     out  1              high from the cycle after start is accepted until frame end
//   done     out  1              1-cycle pulse when the final stop bit completes
// BEHAVIOUR
//   - Reset values: tx=1, busy=0, done=0, FSM=IDLE, all counters 0.
//   - rst is asynchronous. Asserting it mid-frame forces tx=1 and busy=0 at once.
//     The partial frame is abandoned and no done pulse is generated.
//   - FSM states: IDLE -> START_BIT -> DATA_BITS -> STOP_BIT, then back to
//     START_BIT for the next byte, or to IDLE after the checksum byte.
//   - Accept: in IDLE, start=1 latches payload and computes chk = XOR of all payload
//     bytes. From the next cycle, busy=1 and tx=0 (start bit of SYNC_BYTE).
//   - Bit timing: every bit (start, 8 data bits LSB-first, stop=1) holds tx for exactly
//     CLKS_PER_BIT cycles. The baud counter is 16-bit and restarts at every bit boundary.
//   - Byte sequence: index 0 = SYNC_BYTE; 1..NUM_BYTES = payload byte 0..NUM_BYTES-1;
//     NUM_BYTES+1 = chk.
//   - Frame length: (NUM_BYTES+2)*10*CLKS_PER_BIT cycles. There is no idle gap between
//     bytes: the stop bit is followed directly by the next start bit.
//   - Frame end: on the last cycle of the final stop bit, done=1 for 1 cycle.
//     On that same edge the FSM returns to IDLE and busy goes to 0.
//   - start while busy=1 is ignored. There is no queue and no error flag.
//   - payload changes while busy=1 have no effect, because the value was latched at accept.
//   - Back-to-back frames: start=1 in the first cycle with busy=0 is accepted.
//     The minimum gap between frames is the single IDLE cycle (tx=1).
//   - start held high continuously sends frames repeatedly, each latching the current payload.
//   - tx is driven from a register, so there are no combinational glitches.
// TESTING
//   1 Reset: assert rst for 3 cycles mid-idle -> tx=1, busy=0, done=0 throughout.
//   2 Single frame: payload=32'h04030201, start pulse ->
//     bytes A5,01,02,03,04,04 (chk=04) decoded by the bench UART model.
//     Each bit is 434 cycles; done fires 26040 cycles after the first tx-low cycle.
//   3 Checksum: payload=32'hFF00FF00 -> chk=00. payload=32'h80000000 -> chk=80.
//     A bench 8N1 decoder checks every start and stop bit level.
//   4 Ignore while busy: a second start with payload=32'hDEADBEEF at 5000 cycles into
//     the frame -> the frame is still 01,02,03,04. No extra frame follows; busy pulses once.
//   5 Back-to-back: start held high -> two frames separated by exactly 1 idle cycle
//     with tx=1; done pulses twice.
//   6 Reset mid-frame: rst during payload byte 2 -> tx=1 immediately, busy=0, no done.
//     A new start afterwards sends a clean full frame beginning with A5.

Source files
------------

// File: rtl/uart_result_tx.sv
// uart_result_tx: 8N1 UART transmitter that returns inference results to the host.
// A start pulse in IDLE latches the payload and sends one frame. The frame is
// SYNC_BYTE, then the payload bytes LSB-byte-first, then the XOR of all payload bytes.
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   start    frame request, honoured only while busy=0
//   payload  result word, byte k = payload[8k+7:8k]
//   tx       serial line, idle high, registered
//   busy     high while a frame is in flight
//   done     one-cycle pulse when the final stop bit ends
module uart_result_tx #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115_200,
  parameter int unsigned NUM_BYTES = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*NUM_BYTES-1:0] payload,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned PAY_W        = 8 * NUM_BYTES;
  localparam int unsigned IDX_W        = $clog2(NUM_BYTES + 2);
  localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [PAY_W-1:0] payload_q, payload_d;
  logic [7:0]       chk_q, chk_d;
  logic             tx_d, busy_d, done_d;
  logic [7:0]       pay_xor_c;
  logic [7:0]       next_byte_c;
  logic             bit_end_c;

  // Checksum of the live payload input, captured at accept.
  always_comb begin
    pay_xor_c = '0;
    for (int unsigned k = 0; k < NUM_BYTES; k++) begin
      pay_xor_c = pay_xor_c ^ payload[8*k +: 8];
    end
  end

  // Byte that follows frame index idx_q: payload byte idx_q, or the checksum.
  always_comb begin
    next_byte_c = SYNC_BYTE;
    for (int unsigned k = 0; k < NUM_BYTES; k++) begin
      if (idx_q == IDX_W'(k)) next_byte_c = payload_q[8*k +: 8];
    end
    if (idx_q == IDX_W'(NUM_BYTES)) next_byte_c = chk_q;
  end

  assign bit_end_c = (baud_q == BAUD_LAST);

  // Next-state and next-output logic; tx/busy/done are registered below.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    payload_d = payload_q;
    chk_d     = chk_q;
    tx_d      = tx;
    busy_d    = busy;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          payload_d = payload;
          chk_d     = pay_xor_c;
          shreg_d   = SYNC_BYTE;
          idx_d     = '0;
          bit_d     = '0;
          baud_d    = '0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
          state_d   = START_BIT;
        end
      end

      START_BIT: begin
        if (bit_end_c) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
          state_d = DATA_BITS;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      DATA_BITS: begin
        if (bit_end_c) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP_BIT;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {1'b0, shreg_q[7:1]};
            tx_d    = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      STOP_BIT: begin
        if (bit_end_c) begin
          baud_d = '0;
          if (idx_q == LAST_IDX) begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            // No idle gap: the next start bit follows the stop bit directly.
            idx_d   = idx_q + IDX_W'(1);
            shreg_d = next_byte_c;
            tx_d    = 1'b0;
            state_d = START_BIT;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      payload_q <= '0;
      chk_q     <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      payload_q <= payload_d;
      chk_q     <= chk_d;
      tx        <= tx_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule
